io_port_bank: RTL and testbench

//  Multi-channel successor to the single inport/outport pair: NUM_IN buffered input ports and NUM_OUT

---
 rtl/io_port_pkg.sv | 27 ++
 rtl/io_in_fifo.sv | 77 +++++++
 rtl/io_port_bank.sv | 132 +++++++++++++
 tb/tb_io_port_bank.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_port_pkg.sv
// rtl/io_port_pkg.sv - shared defaults, pointer-width helper and port-index type for io_port_bank
//
// Purpose : default widths/depths used as parameter defaults by io_port_bank and io_in_fifo,
//           a clog2-style pointer width function and a port-index typedef.
// Ports   : none (package).

package io_port_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_NUM_IN     = 4;
   localparam int DEF_NUM_OUT    = 4;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DEF_SEL_WIDTH  = 4;

   typedef logic [DEF_SEL_WIDTH-1:0] port_idx_t;

   // Number of bits needed to index 'depth' entries; never less than 1.
   function automatic int ptr_width(input int depth);
      int w;
      w = 1;
      while ((1 << w) < depth) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/io_in_fifo.sv
// rtl/io_in_fifo.sv - show-ahead input FIFO for one io_port_bank input port
//
// Purpose : DEPTH-entry FIFO; head word is visible combinationally (0 when empty).
// Ports   : clk, rst        clock, asynchronous active-high reset
//           push_data/valid device word and its strobe (accepted only when not full)
//           full            count == DEPTH, taken from the registered count
//           pop             consume head (ignored when empty)
//           head_data       current head word, 0 when empty
//           empty           count == 0

module io_in_fifo
   import io_port_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  push_valid,
   output logic                  full,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  empty
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = PW + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  do_push, do_pop;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign do_push   = push_valid & ~full;
   // A pop on an empty FIFO is dropped even if a push lands in the same cycle.
   assign do_pop    = pop & ~empty;
   assign head_data = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/io_port_bank.sv
// rtl/io_port_bank.sv - buffered multi-channel input ports and handshaked output ports
//
// Purpose : NUM_IN show-ahead input FIFOs read by the 'in' instruction and NUM_OUT holding
//           registers written by the 'out' instruction, both addressed by port_sel.
// Config  : IO_OUT_OVERRUN_EN - when defined, out_overrun[i] latches an overwrite of an
//           unacknowledged word until clear; otherwise out_overrun is constant 0.
// Ports   : Clock, clear                 clock, asynchronous active-high reset
//           ext_in_data/valid/ready      device-side input streams, one per FIFO
//           port_sel                     port index shared by in and out
//           inport_rd/data/empty         datapath read of the selected FIFO head
//           bus_data, outport_in         datapath write to the selected output register
//           ext_out_data/valid/ack       device-side output words and handshake
//           out_overrun                  sticky overwrite-before-ack flags

module io_port_bank
   import io_port_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_IN     = DEF_NUM_IN,
   parameter int NUM_OUT    = DEF_NUM_OUT,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int SEL_WIDTH  = DEF_SEL_WIDTH
) (
   input  logic                          Clock,
   input  logic                          clear,
   input  logic [NUM_IN*DATA_WIDTH-1:0]  ext_in_data,
   input  logic [NUM_IN-1:0]             ext_in_valid,
   output logic [NUM_IN-1:0]             ext_in_ready,
   input  logic [SEL_WIDTH-1:0]          port_sel,
   input  logic                          inport_rd,
   output logic [DATA_WIDTH-1:0]         inport_data,
   output logic                          inport_empty,
   input  logic [DATA_WIDTH-1:0]         bus_data,
   input  logic                          outport_in,
   output logic [NUM_OUT*DATA_WIDTH-1:0] ext_out_data,
   output logic [NUM_OUT-1:0]            ext_out_valid,
   input  logic [NUM_OUT-1:0]            ext_out_ack,
   output logic [NUM_OUT-1:0]            out_overrun
);

   logic [NUM_IN-1:0][DATA_WIDTH-1:0]  fifo_head;
   logic [NUM_IN-1:0]                  fifo_empty;
   logic [NUM_IN-1:0]                  fifo_full;
   logic [NUM_IN-1:0]                  fifo_pop;

   logic [NUM_OUT-1:0][DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [NUM_OUT-1:0]                 out_valid_q, out_valid_d;
   logic [NUM_OUT-1:0]                 out_wr;

   // ---------------- input side ----------------
   for (genvar g = 0; g < NUM_IN; g++) begin : g_in
      // An out-of-range port_sel never equals g, so invalid selects pop nothing.
      assign fifo_pop[g] = inport_rd & (port_sel == SEL_WIDTH'(g));

      io_in_fifo #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (FIFO_DEPTH)
      ) u_fifo (
         .clk        (Clock),
         .rst        (clear),
         .push_data  (ext_in_data[g*DATA_WIDTH +: DATA_WIDTH]),
         .push_valid (ext_in_valid[g]),
         .full       (fifo_full[g]),
         .pop        (fifo_pop[g]),
         .head_data  (fifo_head[g]),
         .empty      (fifo_empty[g])
      );
   end

   assign ext_in_ready = ~fifo_full;

   always_comb begin
      inport_data  = '0;
      inport_empty = 1'b1;
      for (int i = 0; i < NUM_IN; i++) begin
         if (port_sel == SEL_WIDTH'(i)) begin
            inport_data  = fifo_head[i];
            inport_empty = fifo_empty[i];
         end
      end
   end

   // ---------------- output side ----------------
   // A write in the same cycle as an ack wins: the new word stays valid.
   always_comb begin
      out_wr      = '0;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      for (int i = 0; i < NUM_OUT; i++) begin
         out_wr[i] = outport_in & (port_sel == SEL_WIDTH'(i));
         if (out_wr[i]) begin
            out_data_d[i]  = bus_data;
            out_valid_d[i] = 1'b1;
         end else if (ext_out_ack[i]) begin
            out_valid_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge Clock or posedge clear) begin
      if (clear) begin
         out_data_q  <= '0;
         out_valid_q <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign ext_out_data  = out_data_q;
   assign ext_out_valid = out_valid_q;

`ifdef IO_OUT_OVERRUN_EN
   logic [NUM_OUT-1:0] overrun_q, overrun_d;

   // Overrun only when the previous word is replaced without being acknowledged.
   assign overrun_d = overrun_q | (out_wr & out_valid_q & ~ext_out_ack);

   always_ff @(posedge Clock or posedge clear) begin
      if (clear) begin
         overrun_q <= '0;
      end else begin
         overrun_q <= overrun_d;
      end
   end

   assign out_overrun = overrun_q;
`else
   assign out_overrun = '0;
`endif

endmodule

// File: tb/tb_io_port_bank.sv
// tb/tb_io_port_bank.sv - directed self-checking bench for io_port_bank

module tb_io_port_bank;

   localparam int DW  = 32;
   localparam int NI  = 4;
   localparam int NO  = 4;
   localparam int SW  = 4;

`ifdef IO_OUT_OVERRUN_EN
   localparam logic OVR_EXP = 1'b1;
`else
   localparam logic OVR_EXP = 1'b0;
`endif

   logic              Clock = 1'b0;
   logic              clear;
   logic [NI*DW-1:0]  ext_in_data;
   logic [NI-1:0]     ext_in_valid;
   logic [NI-1:0]     ext_in_ready;
   logic [SW-1:0]     port_sel;
   logic              inport_rd;
   logic [DW-1:0]     inport_data;
   logic              inport_empty;
   logic [DW-1:0]     bus_data;
   logic              outport_in;
   logic [NO*DW-1:0]  ext_out_data;
   logic [NO-1:0]     ext_out_valid;
   logic [NO-1:0]     ext_out_ack;
   logic [NO-1:0]     out_overrun;

   int total = 0;
   int bad   = 0;

   io_port_bank #(
      .DATA_WIDTH (DW),
      .NUM_IN     (NI),
      .NUM_OUT    (NO),
      .FIFO_DEPTH (4),
      .SEL_WIDTH  (SW)
   ) dut (
      .Clock         (Clock),
      .clear         (clear),
      .ext_in_data   (ext_in_data),
      .ext_in_valid  (ext_in_valid),
      .ext_in_ready  (ext_in_ready),
      .port_sel      (port_sel),
      .inport_rd     (inport_rd),
      .inport_data   (inport_data),
      .inport_empty  (inport_empty),
      .bus_data      (bus_data),
      .outport_in    (outport_in),
      .ext_out_data  (ext_out_data),
      .ext_out_valid (ext_out_valid),
      .ext_out_ack   (ext_out_ack),
      .out_overrun   (out_overrun)
   );

   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      total++; if (inport_empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", inport_empty); end
      total++; if (inport_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", inport_data); end
      total++; if (ext_in_ready !== 4'hF) begin bad++; $display("FAIL rst_ready got=%b exp=1111", ext_in_ready); end
      total++; if (ext_out_valid !== 4'h0) begin bad++; $display("FAIL rst_valid got=%b exp=0000", ext_out_valid); end
      total++; if (out_overrun !== 4'h0) begin bad++; $display("FAIL rst_overrun got=%b exp=0000", out_overrun); end
      // Load FIFO0 with 3 words and output 1 with a word, then clear mid-stream.
      ext_in_valid[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ext_in_data[0 +: DW] = 32'h100 + k;
         tick();
      end
      ext_in_valid[0] = 1'b0;
      port_sel = 4'd1; bus_data = 32'h55; outport_in = 1'b1;
      tick();
      outport_in = 1'b0; port_sel = 4'd0;
      #1;
      total++; if (inport_empty !== 1'b0) begin bad++; $display("FAIL pre_clr_empty got=%b exp=0", inport_empty); end
      total++; if (inport_data !== 32'h100) begin bad++; $display("FAIL pre_clr_head got=%h exp=100", inport_data); end
      clear = 1'b1;
      #1;
      total++; if (inport_empty !== 1'b1) begin bad++; $display("FAIL async_clr_empty got=%b exp=1", inport_empty); end
      total++; if (ext_out_valid !== 4'h0) begin bad++; $display("FAIL async_clr_valid got=%b exp=0000", ext_out_valid); end
      tick();
      clear = 1'b0;
      #1;
      total++; if (inport_empty !== 1'b1) begin bad++; $display("FAIL clr_empty got=%b exp=1", inport_empty); end
      total++; if (ext_in_ready !== 4'hF) begin bad++; $display("FAIL clr_ready got=%b exp=1111", ext_in_ready); end
      total++; if (ext_out_data !== '0) begin bad++; $display("FAIL clr_out_data got=%h exp=0", ext_out_data); end
   endtask

   task automatic test_fill_wrap();
      ext_in_valid[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ext_in_data[DW +: DW] = 32'hA0 + k;
         tick();
         total++;
         if (ext_in_ready[1] !== (k < 3)) begin
            bad++; $display("FAIL fill_ready push=%0d got=%b exp=%b", k, ext_in_ready[1], (k < 3));
         end
      end
      ext_in_valid[1] = 1'b0;
      port_sel = 4'd1;
      for (int k = 0; k < 2; k++) begin
         #1;
         total++; if (inport_data !== 32'hA0 + k) begin bad++; $display("FAIL wrap_rd%0d got=%h exp=%h", k, inport_data, 32'hA0 + k); end
         inport_rd = 1'b1;
         tick();
         inport_rd = 1'b0;
      end
      total++; if (ext_in_ready[1] !== 1'b1) begin bad++; $display("FAIL wrap_ready_mid got=%b exp=1", ext_in_ready[1]); end
      ext_in_valid[1] = 1'b1;
      for (int k = 4; k < 6; k++) begin
         ext_in_data[DW +: DW] = 32'hA0 + k;
         tick();
      end
      ext_in_valid[1] = 1'b0;
      total++; if (ext_in_ready[1] !== 1'b0) begin bad++; $display("FAIL wrap_ready_full got=%b exp=0", ext_in_ready[1]); end
      for (int k = 2; k < 6; k++) begin
         #1;
         total++; if (inport_data !== 32'hA0 + k) begin bad++; $display("FAIL wrap_rd%0d got=%h exp=%h", k, inport_data, 32'hA0 + k); end
         inport_rd = 1'b1;
         tick();
         inport_rd = 1'b0;
      end
      total++; if (inport_empty !== 1'b1) begin bad++; $display("FAIL wrap_drained got=%b exp=1", inport_empty); end
   endtask

   task automatic test_simul_push_pop();
      ext_in_valid[2] = 1'b1;
      ext_in_data[2*DW +: DW] = 32'hB0; tick();
      ext_in_data[2*DW +: DW] = 32'hB1; tick();
      ext_in_valid[2] = 1'b0;
      port_sel = 4'd2;
      #1;
      total++; if (inport_data !== 32'hB0) begin bad++; $display("FAIL sim_head got=%h exp=b0", inport_data); end
      ext_in_valid[2] = 1'b1; ext_in_data[2*DW +: DW] = 32'hB2; inport_rd = 1'b1;
      tick();
      ext_in_valid[2] = 1'b0; inport_rd = 1'b0;
      total++; if (inport_data !== 32'hB1) begin bad++; $display("FAIL sim_after got=%h exp=b1", inport_data); end
      inport_rd = 1'b1; tick();
      total++; if (inport_data !== 32'hB2) begin bad++; $display("FAIL sim_second got=%h exp=b2", inport_data); end
      tick(); inport_rd = 1'b0;
      total++; if (inport_empty !== 1'b1) begin bad++; $display("FAIL sim_count2 empty got=%b exp=1", inport_empty); end
      // Pop on empty: ignored, data reads 0.
      inport_rd = 1'b1; tick(); inport_rd = 1'b0;
      total++; if (inport_data !== 32'h0) begin bad++; $display("FAIL empty_pop_data got=%h exp=0", inport_data); end
      total++; if (ext_in_ready[2] !== 1'b1) begin bad++; $display("FAIL empty_pop_ready got=%b exp=1", ext_in_ready[2]); end
      // Push + pop on empty: word kept, pop dropped.
      ext_in_valid[2] = 1'b1; ext_in_data[2*DW +: DW] = 32'hC0; inport_rd = 1'b1;
      tick();
      ext_in_valid[2] = 1'b0; inport_rd = 1'b0;
      total++; if (inport_empty !== 1'b0) begin bad++; $display("FAIL empty_pp_empty got=%b exp=0", inport_empty); end
      total++; if (inport_data !== 32'hC0) begin bad++; $display("FAIL empty_pp_data got=%h exp=c0", inport_data); end
      inport_rd = 1'b1; tick(); inport_rd = 1'b0;
      total++; if (inport_empty !== 1'b1) begin bad++; $display("FAIL empty_pp_drain got=%b exp=1", inport_empty); end
   endtask

   task automatic test_out_handshake();
      port_sel = 4'd3; bus_data = 32'h12345678; outport_in = 1'b1;
      tick();
      outport_in = 1'b0;
      total++; if (ext_out_valid !== 4'b1000) begin bad++; $display("FAIL hs_valid got=%b exp=1000", ext_out_valid); end
      total++; if (ext_out_data[3*DW +: DW] !== 32'h12345678) begin bad++; $display("FAIL hs_data got=%h exp=12345678", ext_out_data[3*DW +: DW]); end
      tick();
      total++; if (ext_out_valid !== 4'b1000) begin bad++; $display("FAIL hs_hold got=%b exp=1000", ext_out_valid); end
      ext_out_ack[3] = 1'b1; tick(); ext_out_ack[3] = 1'b0;
      total++; if (ext_out_valid !== 4'b0000) begin bad++; $display("FAIL hs_ack got=%b exp=0000", ext_out_valid); end
      ext_out_ack[3] = 1'b1; tick(); ext_out_ack[3] = 1'b0;
      total++; if (ext_out_valid !== 4'b0000) begin bad++; $display("FAIL hs_idle_ack got=%b exp=0000", ext_out_valid); end
      total++; if (out_overrun !== 4'b0000) begin bad++; $display("FAIL hs_overrun got=%b exp=0000", out_overrun); end
   endtask

   task automatic test_overrun();
      outport_in = 1'b1; port_sel = 4'd0;
      bus_data = 32'h11; tick();
      bus_data = 32'h22; tick();
      outport_in = 1'b0;
      total++; if (ext_out_data[0 +: DW] !== 32'h22) begin bad++; $display("FAIL ovr_data got=%h exp=22", ext_out_data[0 +: DW]); end
      total++; if (ext_out_valid[0] !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", ext_out_valid[0]); end
      total++; if (out_overrun[0] !== OVR_EXP) begin bad++; $display("FAIL ovr_flag got=%b exp=%b", out_overrun[0], OVR_EXP); end
      outport_in = 1'b1; port_sel = 4'd1;
      bus_data = 32'h33; tick();
      bus_data = 32'h44; ext_out_ack[1] = 1'b1; tick();
      outport_in = 1'b0; ext_out_ack[1] = 1'b0;
      total++; if (ext_out_valid[1] !== 1'b1) begin bad++; $display("FAIL wa_valid got=%b exp=1", ext_out_valid[1]); end
      total++; if (ext_out_data[DW +: DW] !== 32'h44) begin bad++; $display("FAIL wa_data got=%h exp=44", ext_out_data[DW +: DW]); end
      total++; if (out_overrun[1] !== 1'b0) begin bad++; $display("FAIL wa_overrun got=%b exp=0", out_overrun[1]); end
      ext_out_ack = 4'b0011; tick(); ext_out_ack = 4'b0000;
      total++; if (ext_out_valid !== 4'b0000) begin bad++; $display("FAIL ovr_acked got=%b exp=0000", ext_out_valid); end
      total++; if (out_overrun !== {3'b000, OVR_EXP}) begin bad++; $display("FAIL ovr_sticky got=%b exp=%b", out_overrun, {3'b000, OVR_EXP}); end
   endtask

   task automatic test_invalid_sel();
      ext_in_valid[3] = 1'b1; ext_in_data[3*DW +: DW] = 32'hD0; tick(); ext_in_valid[3] = 1'b0;
      port_sel = 4'd9;
      #1;
      total++; if (inport_empty !== 1'b1) begin bad++; $display("FAIL inv_empty got=%b exp=1", inport_empty); end
      total++; if (inport_data !== 32'h0) begin bad++; $display("FAIL inv_data got=%h exp=0", inport_data); end
      inport_rd = 1'b1; outport_in = 1'b1; bus_data = 32'hDEAD;
      tick();
      inport_rd = 1'b0; outport_in = 1'b0;
      total++; if (ext_out_valid !== 4'b0000) begin bad++; $display("FAIL inv_valid got=%b exp=0000", ext_out_valid); end
      total++;
      if (ext_out_data !== {32'h12345678, 32'h0, 32'h44, 32'h22}) begin
         bad++; $display("FAIL inv_out_data got=%h exp=%h", ext_out_data, {32'h12345678, 32'h0, 32'h44, 32'h22});
      end
      port_sel = 4'd3;
      #1;
      total++; if (inport_data !== 32'hD0) begin bad++; $display("FAIL inv_fifo_kept got=%h exp=d0", inport_data); end
   endtask

   task automatic test_in_and_out_together();
      // port_sel=3 still holds D0 in FIFO3; read it and write output 3 in one cycle.
      inport_rd = 1'b1; outport_in = 1'b1; bus_data = 32'h77;
      tick();
      inport_rd = 1'b0; outport_in = 1'b0;
      total++; if (inport_empty !== 1'b1) begin bad++; $display("FAIL both_popped got=%b exp=1", inport_empty); end
      total++; if (ext_out_valid !== 4'b1000) begin bad++; $display("FAIL both_valid got=%b exp=1000", ext_out_valid); end
      total++; if (ext_out_data[3*DW +: DW] !== 32'h77) begin bad++; $display("FAIL both_data got=%h exp=77", ext_out_data[3*DW +: DW]); end
   endtask

   initial begin
      clear        = 1'b1;
      ext_in_data  = '0;
      ext_in_valid = '0;
      port_sel     = '0;
      inport_rd    = 1'b0;
      bus_data     = '0;
      outport_in   = 1'b0;
      ext_out_ack  = '0;
      repeat (2) @(posedge Clock);
      #1;
      clear = 1'b0;
      #1;
      test_reset();
      test_fill_wrap();
      test_simul_push_pop();
      test_out_handshake();
      test_overrun();
      test_invalid_sel();
      test_in_and_out_together();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
